gray_updown_counter: RTL

Parametrised synchronous Gray-code counter: the successor to the team's fixed-direction 4-bit Gray counter. It adds up/down counting, count enable, synchronous Gray-value load, optional saturation, a wrap/limit pulse and a binary-view output. Its Gray output updates in the same cycle as the internal binary state, with no extra pipeline lag. Intended for FIFO pointers and position counters that cross clock domains.

---
 rtl/gray_updown_counter.sv | 112 +++++++++++
 1 files changed

// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray-code counter with load, optional saturation, wrap pulse and binary view.
// Optional Gray-step checker enabled by defining GRAY_CHECK_EN; otherwise err is tied low.
module gray_updown_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_count,
  output logic [WIDTH-1:0] bin_count,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] MIN_VAL  = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Load beats counting; at a limit the step either wraps or holds, and both raise wrap.
  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = gray_to_bin(load_gray);
    end else if (en) begin
      if (up) begin
        if (bin_q == MAX_VAL) begin
          wrap_next = 1'b1;
          bin_next  = SATURATE ? MAX_VAL : MIN_VAL;
        end else begin
          bin_next = bin_q + ONE;
        end
      end else begin
        if (bin_q == MIN_VAL) begin
          wrap_next = 1'b1;
          bin_next  = SATURATE ? MIN_VAL : MAX_VAL;
        end else begin
          bin_next = bin_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= bin_next ^ (bin_next >> 1);
      wrap_q <= wrap_next;
    end
  end

  assign bin_count  = bin_q;
  assign gray_count = gray_q;
  assign wrap       = wrap_q;

`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             step_flag;
  logic             stepped;
  logic             err_q;
  logic [WIDTH-1:0] gray_diff;
  logic             one_bit;

  // Only count steps that actually moved B are checked; loads and saturated holds are exempt.
  assign stepped   = !load && en && (bin_next != bin_q);
  assign gray_diff = gray_q ^ prev_gray;
  assign one_bit   = (gray_diff != '0) && ((gray_diff & (gray_diff - ONE)) == '0);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      prev_gray <= '0;
      step_flag <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      prev_gray <= gray_q;
      step_flag <= stepped;
      if (step_flag && !one_bit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
